msrv32_decode_issue_ctrl: RTL and testbench
===========================================

// Module: msrv32_decode_issue_ctrl
// PURPOSE
//  Decode-stage issue controller: accepts fetched instructions over valid/ready, decodes opcode to the
//  immediate-type code, and presents instr[31:7] + imm_type to msrv32_imm_generator and the execute stage.
//  Contains a 2-entry skid buffer (main + skid) so fetch ready never depends combinationally on execute.
//  Handles pipeline flush (taken branch/jump) and counts issued instructions.
// PARAMETERS
//  CNT_W      16            width of issued-instruction counter
//  RESET_NOP  32'h00000013  instruction held on outputs after reset/flush (addi x0,x0,0)
// PORTS
//  clk_in          in   1      clock, all state on rising edge
//  rst_in          in   1      synchronous, active-high reset
//  instr_in        in   32     instruction from fetch
//  instr_valid_in  in   1      fetch has instruction
//  instr_ready_out out  1      controller can accept (=state!=FULL)
//  flush_in        in   1      discard all buffered and incoming instructions
//  dec_ready_in    in   1      execute stage accepts current output
//  dec_valid_out   out  1      outputs hold a valid decoded instruction
//  instr_out       out  25     instr[31:7] of main entry, drives imm generator instr_in
//  imm_type_out    out  3      imm type code to imm generator (table below)
//  opcode_out      out  7      instr[6:0] of main entry
//  illegal_out     out  1      main entry has unsupported opcode
//  issue_cnt_out   out  CNT_W  count of output handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state EMPTY; dec_valid_out=0; instr_out=RESET_NOP[31:7]; opcode_out=RESET_NOP[6:0];
//   imm_type_out=3'b001; illegal_out=0; issue_cnt_out=0; instr_ready_out=1. Reset wins over all inputs.
//  Accept = instr_valid_in & instr_ready_out; Issue = dec_valid_out & dec_ready_in.
//  Decode done at capture; instr, opcode, imm_type, illegal registered together per entry.
//  Latency: instruction accepted in cycle N appears on outputs in N+1 (EMPTY) with dec_valid_out=1.
//  Imm-type table (opcode -> code): 0010011/0000011/1100111 -> 001 I; 0100011 -> 010 S;
//   1100011 -> 011 B; 0110111/0010111 -> 100 U; 1101111 -> 101 J; 1110011 -> 110 CSR;
//   0110011/0001111 -> 000 none. Any other opcode (incl. bits[1:0]!=2'b11): code 000, illegal=1.
//  Illegal entries still issue normally; execute handles trap.
//  FSM (dec_valid_out = state!=EMPTY):
//   EMPTY: Accept -> ONE (load main). else stay.
//   ONE:   Accept&Issue -> ONE (main<=new); Accept&!Issue -> FULL (skid<=new);
//          !Accept&Issue -> EMPTY; else hold.
//   FULL:  instr_ready_out=0; Issue -> ONE (main<=skid); else hold. No Accept possible.
//  Outputs stable (no change) while dec_valid_out=1 and dec_ready_in=0; order strictly FIFO.
//  flush_in: next state EMPTY regardless of state; same-cycle Accept discarded; main outputs
//   reloaded with RESET_NOP decode; issue in the flush cycle still counts if Issue true.
//  flush_in & rst_in same cycle: reset behaviour.
//  issue_cnt_out += 1 on every Issue; wraps from 2^CNT_W-1 to 0; not cleared by flush.
//  When EMPTY, instr_out/imm_type_out hold last loaded values (or NOP); consumers qualify with dec_valid_out.
// TESTING
//  Reset: rst_in=1 2 cycles, random inputs -> dec_valid_out=0, instr_ready_out=1, instr_out=0, imm_type=001, cnt=0.
//  Stream dec_ready_in=1: 0x00500093, 0xFE208EE3, 0x123452B7, 0x0040006F -> imm_type 001,011,100,101
//   one per cycle, 1-cycle latency, cnt=4, instr_out=instr[31:7] each.
//  Backpressure: dec_ready_in=0, send 0x00A12023 then 0x00000073 -> state FULL, ready_out=0,
//   outputs hold S(010); raise dec_ready_in -> CSR(110) next, then EMPTY; cnt +2, order preserved.
//  Flush in FULL with instr_valid_in=1, dec_ready_in=0 -> next cycle dec_valid_out=0, ready_out=1,
//   cnt unchanged, flushed and incoming instructions never issued.
//  Illegal: 0xFFFFFFFF and 0x00000000 -> illegal_out=1, imm_type 000, both issue, cnt+2.
//  Counter wrap with CNT_W=4: 17 issues -> cnt=1; reset asserted while FULL -> EMPTY, cnt=0 next cycle.

Source files
------------

// File: rtl/msrv32_decode_issue_ctrl_if.sv
// Fetch-side and execute-side handshake bundle of the decode/issue controller.
// The controller connects through the slave modport; the driver of fetch
// instructions and execute ready (e.g. a testbench or the pipeline top)
// uses the master modport.
interface msrv32_decode_issue_ctrl_if #(
  parameter int CNT_W = 16
);
  // fetch side
  logic [31:0]      instr_in;
  logic             instr_valid_in;
  logic             instr_ready_out;
  // pipeline control
  logic             flush_in;
  // execute / immediate-generator side
  logic             dec_ready_in;
  logic             dec_valid_out;
  logic [24:0]      instr_out;
  logic [2:0]       imm_type_out;
  logic [6:0]       opcode_out;
  logic             illegal_out;
  logic [CNT_W-1:0] issue_cnt_out;

  modport slave (
    input  instr_in, instr_valid_in, flush_in, dec_ready_in,
    output instr_ready_out, dec_valid_out, instr_out, imm_type_out,
           opcode_out, illegal_out, issue_cnt_out
  );

  modport master (
    output instr_in, instr_valid_in, flush_in, dec_ready_in,
    input  instr_ready_out, dec_valid_out, instr_out, imm_type_out,
           opcode_out, illegal_out, issue_cnt_out
  );
endinterface

// File: rtl/msrv32_decode_issue_ctrl.sv
// Decode-stage issue controller for msrv32.
// Accepts fetched instructions, decodes the opcode into an immediate-type
// code at capture time and presents the oldest entry to the immediate
// generator / execute stage. A main + skid entry pair keeps fetch ready a
// pure function of registered state, so it never depends combinationally
// on execute ready. Flush empties both entries and reloads the outputs with
// a NOP; an issue counter records every output handshake.
module msrv32_decode_issue_ctrl #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  msrv32_decode_issue_ctrl_if.slave         bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Opcode -> {illegal, imm_type}. Anything not listed (including compressed
  // encodings with bits[1:0] != 2'b11) is illegal with no immediate.
  function automatic logic [3:0] decode_op(input logic [6:0] op);
    logic [3:0] res;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: res = 4'b0_001; // I
      7'b0100011:                         res = 4'b0_010; // S
      7'b1100011:                         res = 4'b0_011; // B
      7'b0110111, 7'b0010111:             res = 4'b0_100; // U
      7'b1101111:                         res = 4'b0_101; // J
      7'b1110011:                         res = 4'b0_110; // CSR
      7'b0110011, 7'b0001111:             res = 4'b0_000; // R-type / fence
      default:                            res = 4'b1_000; // unsupported
    endcase
    return res;
  endfunction

  localparam logic [3:0] NOP_DEC = decode_op(RESET_NOP[6:0]);

  state_t           state_q, state_d;
  logic [31:0]      main_instr_q, main_instr_d;
  logic [2:0]       main_imm_q, main_imm_d;
  logic             main_ill_q, main_ill_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic [2:0]       skid_imm_q, skid_imm_d;
  logic             skid_ill_q, skid_ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ready;
  logic             valid;
  logic             accept;
  logic             issue;
  logic [3:0]       in_dec;

  assign ready  = (state_q != ST_FULL);
  assign valid  = (state_q != ST_EMPTY);
  assign accept = bus.instr_valid_in & ready;
  assign issue  = valid & bus.dec_ready_in;
  assign in_dec = decode_op(bus.instr_in[6:0]);

  // Next-state, entry loading and issue counting.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_imm_d   = main_imm_q;
    main_ill_d   = main_ill_q;
    skid_instr_d = skid_instr_q;
    skid_imm_d   = skid_imm_q;
    skid_ill_d   = skid_ill_q;
    cnt_d        = issue ? cnt_q + CNT_ONE : cnt_q;

    if (bus.flush_in) begin
      // An issue in this cycle has already been counted above; whatever is
      // buffered or arriving is dropped.
      state_d      = ST_EMPTY;
      main_instr_d = RESET_NOP;
      main_imm_d   = NOP_DEC[2:0];
      main_ill_d   = NOP_DEC[3];
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            main_instr_d = bus.instr_in;
            main_imm_d   = in_dec[2:0];
            main_ill_d   = in_dec[3];
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            main_instr_d = bus.instr_in;
            main_imm_d   = in_dec[2:0];
            main_ill_d   = in_dec[3];
          end else if (accept) begin
            state_d      = ST_FULL;
            skid_instr_d = bus.instr_in;
            skid_imm_d   = in_dec[2:0];
            skid_ill_d   = in_dec[3];
          end else if (issue) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (issue) begin
            state_d      = ST_ONE;
            main_instr_d = skid_instr_q;
            main_imm_d   = skid_imm_q;
            main_ill_d   = skid_ill_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and entry registers; reset overrides flush and all handshakes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= RESET_NOP;
      main_imm_q   <= NOP_DEC[2:0];
      main_ill_q   <= NOP_DEC[3];
      skid_instr_q <= RESET_NOP;
      skid_imm_q   <= NOP_DEC[2:0];
      skid_ill_q   <= NOP_DEC[3];
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_imm_q   <= main_imm_d;
      main_ill_q   <= main_ill_d;
      skid_instr_q <= skid_instr_d;
      skid_imm_q   <= skid_imm_d;
      skid_ill_q   <= skid_ill_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.instr_ready_out = ready;
  assign bus.dec_valid_out   = valid;
  assign bus.instr_out       = main_instr_q[31:7];
  assign bus.opcode_out      = main_instr_q[6:0];
  assign bus.imm_type_out    = main_imm_q;
  assign bus.illegal_out     = main_ill_q;
  assign bus.issue_cnt_out   = cnt_q;

endmodule

// File: tb/tb_msrv32_decode_issue_ctrl.sv
// Randomized and directed bench for msrv32_decode_issue_ctrl. A queue-based
// reference model (at most two buffered instructions, head on the outputs)
// predicts every output each cycle. The counter is built 4 bits wide so wrap
// is reachable quickly.
module tb_msrv32_decode_issue_ctrl;

  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;

  msrv32_decode_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  msrv32_decode_issue_ctrl #(.CNT_W(CNT_W), .RESET_NOP(NOP)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] q[$];
  logic [31:0] disp;
  int          cnt;
  bit          known = 0;
  int          n_issued = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Immediate-type table as listed for the decoder: returns {illegal, code}.
  function automatic logic [3:0] ref_decode(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 4'h1;
    if (op == 7'h23) return 4'h2;
    if (op == 7'h63) return 4'h3;
    if (op == 7'h37 || op == 7'h17) return 4'h4;
    if (op == 7'h6F) return 4'h5;
    if (op == 7'h73) return 4'h6;
    if (op == 7'h33 || op == 7'h0F) return 4'h0;
    return 4'h8;
  endfunction

  task automatic compare_outputs();
    logic [3:0] d;
    d = ref_decode(disp);
    check_eq("dec_valid", {31'd0, bus.dec_valid_out}, {31'd0, q.size() > 0});
    check_eq("ready",     {31'd0, bus.instr_ready_out}, {31'd0, q.size() < 2});
    check_eq("instr",     {7'd0, bus.instr_out}, {7'd0, disp[31:7]});
    check_eq("opcode",    {25'd0, bus.opcode_out}, {25'd0, disp[6:0]});
    check_eq("imm_type",  {29'd0, bus.imm_type_out}, {29'd0, d[2:0]});
    check_eq("illegal",   {31'd0, bus.illegal_out}, {31'd0, d[3]});
    check_eq("cnt",       {28'd0, bus.issue_cnt_out}, cnt);
  endtask

  // One clock cycle: drive, compare mid-cycle, then advance the model.
  task automatic step(input bit r, input bit v, input logic [31:0] ins, input bit fl, input bit dr);
    bit acc;
    bit iss;
    rst                = r;
    bus.instr_valid_in = v;
    bus.instr_in       = ins;
    bus.flush_in       = fl;
    bus.dec_ready_in   = dr;
    @(negedge clk);
    if (known) compare_outputs();
    acc = v && (q.size() < 2);
    iss = dr && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      disp  = NOP;
      cnt   = 0;
      known = 1;
    end else if (known) begin
      if (iss) begin
        n_issued++;
        $display("issue %0d: instr=%h cnt->%0d%s", n_issued, q[0], (cnt + 1) % 16,
                 fl ? " (flush cycle)" : "");
        cnt = (cnt + 1) % 16;
        void'(q.pop_front());
      end
      if (fl) begin
        q.delete();
        disp = NOP;
      end else if (acc) begin
        q.push_back(ins);
      end
      if (q.size() > 0) disp = q[0];
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops[12];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F};
    r = $urandom();
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  initial begin
    logic [31:0] stream[4];
    rst = 1'b0;
    bus.instr_valid_in = 1'b0;
    bus.instr_in = '0;
    bus.flush_in = 1'b0;
    bus.dec_ready_in = 1'b0;

    // reset with random inputs
    step(1, 1'($urandom()), $urandom(), 1'($urandom()), 1'($urandom()));
    step(1, 1'($urandom()), $urandom(), 1'($urandom()), 1'($urandom()));
    step(0, 0, 32'h0, 0, 1);
    check_eq("rst_instr0", {7'd0, bus.instr_out}, 32'h0);
    check_eq("rst_imm001", {29'd0, bus.imm_type_out}, 32'h1);

    // streaming at full rate
    stream = '{32'h00500093, 32'hFE208EE3, 32'h123452B7, 32'h0040006F};
    foreach (stream[i]) step(0, 1, stream[i], 0, 1);
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    check_eq("stream_cnt", {28'd0, bus.issue_cnt_out}, 32'd4);

    // backpressure: fill both entries, then drain
    step(0, 1, 32'h00A12023, 0, 0);
    step(0, 1, 32'h00000073, 0, 0);
    step(0, 1, 32'h00000013, 0, 0);
    check_eq("bp_ready", {31'd0, bus.instr_ready_out}, 32'd0);
    check_eq("bp_imm_s", {29'd0, bus.imm_type_out}, 32'd2);
    step(0, 0, 32'h0, 0, 1);
    check_eq("bp_imm_csr", {29'd0, bus.imm_type_out}, 32'd6);
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 0);
    check_eq("bp_cnt", {28'd0, bus.issue_cnt_out}, 32'd6);

    // flush while FULL with an incoming instruction
    step(0, 1, 32'h00100093, 0, 0);
    step(0, 1, 32'h00200093, 0, 0);
    step(0, 1, 32'h00300093, 1, 0);
    step(0, 0, 32'h0, 0, 1);
    check_eq("fl_valid", {31'd0, bus.dec_valid_out}, 32'd0);
    check_eq("fl_cnt", {28'd0, bus.issue_cnt_out}, 32'd6);

    // illegal encodings still issue
    step(0, 1, 32'hFFFFFFFF, 0, 1);
    step(0, 1, 32'h00000000, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 0);
    check_eq("ill_cnt", {28'd0, bus.issue_cnt_out}, 32'd8);

    // counter wrap: 17 issues from reset
    step(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, rand_instr(), 0, 1);
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 0);
    check_eq("wrap_cnt", {28'd0, bus.issue_cnt_out}, 32'd1);

    // reset while FULL (also with a flush pending)
    step(0, 1, 32'h00000517, 0, 0);
    step(0, 1, 32'h00000597, 0, 0);
    step(1, 1, 32'h00000617, 1, 1);
    step(0, 0, 32'h0, 0, 0);
    check_eq("rstfull_valid", {31'd0, bus.dec_valid_out}, 32'd0);
    check_eq("rstfull_cnt", {28'd0, bus.issue_cnt_out}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 2) != 0,
           rand_instr(),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0);
    end
    step(0, 0, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
